// File: rtl/instr_req_queue.sv
// Fetch-request FIFO to the icache ufp: zero latency with INSTR_REQ_QUEUE_BYPASS_EN, else one cycle minimum to the head.
// cpu_req_ready drops when full or flushing. The head entry is held until ufp_resp. flush kills the in-flight head.
module instr_req_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        cpu_ufp_addr,
    input  logic [MASK_WIDTH-1:0]        cpu_ufp_rmask,
    output logic                         cpu_req_ready,
    input  logic                         flush,
    input  logic                         ufp_resp,
    output logic [ADDR_WIDTH-1:0]        ufp_addr,
    output logic [MASK_WIDTH-1:0]        ufp_rmask,
    output logic                         cpu_resp_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [MASK_WIDTH-1:0] rmask;
    } req_t;

    req_t          mem_q [DEPTH];
    req_t          mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          kill_q, kill_d;

    logic empty;
    logic req_vld;
    logic byp_path;
    logic byp_hit;
    logic pop;
    logic enq;

    assign empty   = (count_q == '0);
    assign req_vld = (cpu_ufp_rmask != '0);

    // Readiness depends only on state and flush, never on the request itself.
    assign cpu_req_ready = rst_n && (count_q != FULL) && !flush;

`ifdef INSTR_REQ_QUEUE_BYPASS_EN
    assign byp_path = rst_n && empty && !flush;
`else
    assign byp_path = 1'b0;
`endif
    assign byp_hit = byp_path && ufp_resp && req_vld;

    assign pop = ufp_resp && !empty;
    assign enq = req_vld && cpu_req_ready && !byp_hit;

    assign cpu_resp_valid = (ufp_resp && !empty && !kill_q && !flush) || byp_hit;
    assign occupancy      = count_q;

    always_comb begin
        ufp_addr  = '0;
        ufp_rmask = '0;
        if (byp_path) begin
            ufp_addr  = cpu_ufp_addr;
            ufp_rmask = cpu_ufp_rmask;
        end else if (!empty) begin
            ufp_addr  = mem_q[head_q].addr;
            ufp_rmask = mem_q[head_q].rmask;
        end
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        kill_d  = kill_q;
        if (flush) begin
            // Keep only the in-flight head; a same-cycle response retires it silently.
            if (!empty) begin
                if (ufp_resp) begin
                    head_d  = head_q + PW'(1);
                    tail_d  = head_q + PW'(1);
                    count_d = '0;
                    kill_d  = 1'b0;
                end else begin
                    tail_d  = head_q + PW'(1);
                    count_d = CW'(1);
                    kill_d  = 1'b1;
                end
            end
        end else begin
            if (enq) begin
                mem_d[tail_q].addr  = cpu_ufp_addr;
                mem_d[tail_q].rmask = cpu_ufp_rmask;
                tail_d              = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
                kill_d = 1'b0;
            end
            case ({enq, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            kill_q  <= kill_d;
        end
    end

endmodule

// File: tb/tb_instr_req_queue.sv
// Bench for instr_req_queue: constant vector table, directed corner sequences, and a queue-based random reference.
module tb_instr_req_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_ufp_addr;
    logic [3:0]  cpu_ufp_rmask;
    logic        cpu_req_ready;
    logic        flush;
    logic        ufp_resp;
    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask;
    logic        cpu_resp_valid;
    logic [2:0]  occupancy;

    instr_req_queue #(.ADDR_WIDTH(32), .MASK_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_ufp_addr   (cpu_ufp_addr),
        .cpu_ufp_rmask  (cpu_ufp_rmask),
        .cpu_req_ready  (cpu_req_ready),
        .flush          (flush),
        .ufp_resp       (ufp_resp),
        .ufp_addr       (ufp_addr),
        .ufp_rmask      (ufp_rmask),
        .cpu_resp_valid (cpu_resp_valid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Values sampled during one cycle.
    logic        s_rdy, s_vld;
    logic [3:0]  s_rm;
    logic [31:0] s_ad;
    int          s_occ;

    task automatic apply(input bit fl, input bit rs, input logic [3:0] rm, input logic [31:0] ad);
        @(negedge clk);
        flush = fl; ufp_resp = rs; cpu_ufp_rmask = rm; cpu_ufp_addr = ad;
        #1;
        s_rdy = cpu_req_ready; s_rm = ufp_rmask; s_ad = ufp_addr; s_vld = cpu_resp_valid;
        @(posedge clk);
        #1;
        s_occ = int'(occupancy);
    endtask

    // Reference model: list of outstanding requests oldest first, plus a killed flag for the oldest.
    typedef struct { logic [31:0] a; logic [3:0] m; } ent_t;
    ent_t mq[$];
    bit   mkill = 0;

    task automatic mcyc(input bit fl, input bit rs, input logic [3:0] rm, input logic [31:0] ad,
                        output bit acc);
        int          cnt;
        bit          byp, byp_take, e_rdy, e_vld;
        logic [3:0]  e_rm;
        logic [31:0] e_ad;
        ent_t        e;
        cnt = mq.size();
        byp = 0;
`ifdef INSTR_REQ_QUEUE_BYPASS_EN
        byp = (cnt == 0) && !fl;
`endif
        e_rdy = (cnt < DEPTH) && !fl;
        if (byp) begin
            e_ad = ad; e_rm = rm;
        end else if (cnt > 0) begin
            e_ad = mq[0].a; e_rm = mq[0].m;
        end else begin
            e_ad = 0; e_rm = 0;
        end
        byp_take = byp && rs && (rm != 0);
        e_vld = rs && ((cnt > 0 && !mkill && !fl) || byp_take);
        apply(fl, rs, rm, ad);
        chk("ready", s_rdy, e_rdy);
        chk("ufp_rmask", s_rm, e_rm);
        chk("ufp_addr", s_ad, e_ad);
        chk("resp_valid", s_vld, e_vld);
        acc = 0;
        if (fl) begin
            if (cnt > 0) begin
                if (rs) begin
                    mq.delete(); mkill = 0;
                end else begin
                    e = mq[0]; mq.delete(); mq.push_back(e); mkill = 1;
                end
            end
        end else begin
            if (rs && cnt > 0) begin
                void'(mq.pop_front()); mkill = 0;
            end
            if (rm != 0 && e_rdy) begin
                acc = 1;
                if (!byp_take) begin
                    e.a = ad; e.m = rm; mq.push_back(e);
                end
            end
        end
        chk("occupancy", s_occ, mq.size());
    endtask

    typedef struct {
        bit fl; bit rs; logic [3:0] rm; logic [31:0] ad;
        bit rdy; logic [3:0] urm; logic [31:0] uad; bit vld; int occ;
    } vec_t;
    vec_t tbl[17];

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] served[$];

        rst_n = 0; flush = 0; ufp_resp = 0; cpu_ufp_rmask = 0; cpu_ufp_addr = 0;
        #12;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_ufp_rmask", ufp_rmask, 0);
        chk("rst_ufp_addr", ufp_addr, 0);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_ready", cpu_req_ready, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("ready_after_rst", cpu_req_ready, 1);

`ifndef INSTR_REQ_QUEUE_BYPASS_EN
        //                fl rs rm    ad            rdy urm   uad           vld occ
        tbl[0]  = '{0, 0, 4'hF, 32'h1000,  1, 4'h0, 32'h0,     0, 1};
        tbl[1]  = '{0, 0, 4'hF, 32'h1004,  1, 4'hF, 32'h1000,  0, 2};
        tbl[2]  = '{0, 0, 4'hF, 32'h1008,  1, 4'hF, 32'h1000,  0, 3};
        tbl[3]  = '{0, 0, 4'hF, 32'h100C,  1, 4'hF, 32'h1000,  0, 4};
        tbl[4]  = '{0, 0, 4'hF, 32'h1010,  0, 4'hF, 32'h1000,  0, 4};
        tbl[5]  = '{0, 1, 4'hF, 32'h1010,  0, 4'hF, 32'h1000,  1, 3};
        tbl[6]  = '{0, 0, 4'h0, 32'h0,     1, 4'hF, 32'h1004,  0, 3};
        tbl[7]  = '{1, 0, 4'hF, 32'h2000,  0, 4'hF, 32'h1004,  0, 1};
        tbl[8]  = '{0, 1, 4'h0, 32'h0,     1, 4'hF, 32'h1004,  0, 0};
        tbl[9]  = '{0, 0, 4'hF, 32'h4000,  1, 4'h0, 32'h0,     0, 1};
        tbl[10] = '{0, 1, 4'h0, 32'h0,     1, 4'hF, 32'h4000,  1, 0};
        tbl[11] = '{0, 0, 4'h3, 32'h5000,  1, 4'h0, 32'h0,     0, 1};
        tbl[12] = '{0, 0, 4'h3, 32'h5004,  1, 4'h3, 32'h5000,  0, 2};
        tbl[13] = '{1, 1, 4'hF, 32'h6000,  0, 4'h3, 32'h5000,  0, 0};
        tbl[14] = '{0, 0, 4'h0, 32'h0,     1, 4'h0, 32'h0,     0, 0};
        tbl[15] = '{1, 0, 4'hF, 32'h7000,  0, 4'h0, 32'h0,     0, 0};
        tbl[16] = '{0, 1, 4'h0, 32'h0,     1, 4'h0, 32'h0,     0, 0};
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].fl, tbl[i].rs, tbl[i].rm, tbl[i].ad);
            chk($sformatf("vec%0d_ready", i), s_rdy, tbl[i].rdy);
            chk($sformatf("vec%0d_ufp_rmask", i), s_rm, tbl[i].urm);
            chk($sformatf("vec%0d_ufp_addr", i), s_ad, tbl[i].uad);
            chk($sformatf("vec%0d_resp_valid", i), s_vld, tbl[i].vld);
            chk($sformatf("vec%0d_occupancy", i), s_occ, tbl[i].occ);
        end
`endif

        // Bypass corner: request meets its response in the same cycle on an empty queue.
        mcyc(0, 1, 4'hF, 32'h5000, acc);
`ifdef INSTR_REQ_QUEUE_BYPASS_EN
        chk("byp_addr_same_cycle", s_ad, 32'h5000);
        chk("byp_resp_valid", s_vld, 1);
        chk("byp_occupancy", s_occ, 0);
`else
        chk("nobyp_rmask_zero", s_rm, 0);
        chk("nobyp_resp_valid", s_vld, 0);
        mcyc(0, 1, 4'h0, 32'h0, acc);
        chk("nobyp_addr_next_cycle", s_ad, 32'h5000);
        chk("nobyp_served", s_vld, 1);
`endif

        // Wrap-around: ten requests, response every other cycle, stalled requests retried.
        idx = 0;
        for (int c = 0; c < 80 && served.size() < 10; c++) begin
            mcyc(0, (c % 2) == 1, (idx < 10) ? 4'hF : 4'h0, 32'h2000 + 32'(4 * idx), acc);
            if (s_vld) served.push_back(s_ad);
            if (acc) idx++;
        end
        chk("wrap_served_count", served.size(), 10);
        for (int i = 0; i < served.size() && i < 10; i++)
            chk($sformatf("wrap_order%0d", i), served[i], 32'h2000 + 32'(4 * i));

        // Randomized run against the reference model.
        for (int c = 0; c < 400; c++) begin
            mcyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 $urandom, acc);
        end

        // Reset asserted between edges with three requests pending.
        while (mq.size() > 0) mcyc(0, 1, 4'h0, 32'h0, acc);
        mcyc(0, 0, 4'h1, 32'h8000, acc);
        mcyc(0, 0, 4'h2, 32'h8004, acc);
        mcyc(0, 0, 4'h4, 32'h8008, acc);
        @(negedge clk);
        cpu_ufp_rmask = 0; ufp_resp = 0; flush = 0;
        #2;
        rst_n = 0;
        #1;
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_ufp_rmask", ufp_rmask, 0);
        chk("midrst_ready", cpu_req_ready, 0);
        mq.delete(); mkill = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("midrst_ready_after", cpu_req_ready, 1);
        mcyc(0, 0, 4'hF, 32'h9000, acc);
        mcyc(0, 1, 4'h0, 32'h0, acc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
